// File: rtl/ball_ctrl_pkg.sv
// Shared types, constants and the velocity-code helper for the ball motion controller.
package ball_ctrl_pkg;

  localparam int unsigned POS_W = 9;
  localparam int unsigned VEL_W = 4;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    EVAL  = 2'd2,
    APPLY = 2'd3
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // Slip code: center offset by speed, upward for dir=1, downward for dir=0.
  function automatic logic [VEL_W-1:0] vel_encode(input logic [VEL_W-1:0] center,
                                                  input logic             dir,
                                                  input logic [VEL_W-1:0] speed);
    return dir ? VEL_W'(center + speed) : VEL_W'(center - speed);
  endfunction

endpackage

// File: rtl/collision_latch.sv
// Sticky per-frame collision flags for the four walls and any paddle/brick overlap.
// Ports: clk, reset (sync, active-high), clear (drops all flags), raster position,
// display_on/ball_gfx/obj_gfx pixel inputs; hit_l/r/t/b/o registered flag outputs.
module collision_latch
  import ball_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned BORDER   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [POS_W-1:0] hpos,
  input  logic [POS_W-1:0] vpos,
  input  logic             display_on,
  input  logic             ball_gfx,
  input  logic             obj_gfx,
  output logic             hit_l,
  output logic             hit_r,
  output logic             hit_t,
  output logic             hit_b,
  output logic             hit_o
);

  logic lit_c;
  assign lit_c = display_on && ball_gfx;

  // Clear wins over a same-cycle set; it is only asserted outside active video.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hit_l <= 1'b0;
      hit_r <= 1'b0;
      hit_t <= 1'b0;
      hit_b <= 1'b0;
      hit_o <= 1'b0;
    end else if (lit_c) begin
      if (hpos <  POS_W'(BORDER))            hit_l <= 1'b1;
      if (hpos >= POS_W'(H_ACTIVE - BORDER)) hit_r <= 1'b1;
      if (vpos <  POS_W'(BORDER))            hit_t <= 1'b1;
      if (vpos >= POS_W'(V_ACTIVE - BORDER)) hit_b <= 1'b1;
      if (obj_gfx)                           hit_o <= 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion controller: serve hold, collision resolution in vblank,
// and the horizontal/vertical slip codes for the ball timers.
// Ports: clk, reset (sync, active-high), hpos/vpos raster, display_on, ball_gfx,
// obj_gfx, serve (level); ball_horiz_vel/ball_vert_vel codes, serving, bounce pulse.
module ball_motion_ctrl
  import ball_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE         = 256,
  parameter int unsigned V_ACTIVE         = 240,
  parameter int unsigned BORDER           = 4,
  parameter int unsigned H_CENTER         = 4,
  parameter int unsigned V_CENTER         = 5,
  parameter int unsigned MAX_SPEED        = 3,
  parameter int unsigned HITS_PER_SPEEDUP = 4,
  parameter int unsigned SERVE_FRAMES     = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] hpos,
  input  logic [POS_W-1:0] vpos,
  input  logic             display_on,
  input  logic             ball_gfx,
  input  logic             obj_gfx,
  input  logic             serve,
  output logic [VEL_W-1:0] ball_horiz_vel,
  output logic [VEL_W-1:0] ball_vert_vel,
  output logic             serving,
  output logic             bounce
);

  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam int unsigned HIT_W = $clog2(HITS_PER_SPEEDUP + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
  logic [HIT_W-1:0] hitcnt, hitcnt_n;
  logic [VEL_W-1:0] speed, speed_n;
  logic             hdir, hdir_n, vdir, vdir_n;
  logic [VEL_W-1:0] hvel_n, vvel_n;
  logic             serving_n, bounce_n;
  logic             clear_c, frame_start_c;
  logic             hit_l, hit_r, hit_t, hit_b, hit_o;

  assign frame_start_c = (hpos == '0) && (vpos == POS_W'(V_ACTIVE));

  collision_latch #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BORDER   (BORDER)
  ) u_collision_latch (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_c),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .ball_gfx   (ball_gfx),
    .obj_gfx    (obj_gfx),
    .hit_l      (hit_l),
    .hit_r      (hit_r),
    .hit_t      (hit_t),
    .hit_b      (hit_b),
    .hit_o      (hit_o)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SERVE;
      frame_cnt      <= '0;
      hitcnt         <= '0;
      speed          <= '0;
      hdir           <= DIR_RIGHT;
      vdir           <= DIR_DOWN;
      ball_horiz_vel <= VEL_W'(H_CENTER);
      ball_vert_vel  <= VEL_W'(V_CENTER);
      serving        <= 1'b1;
      bounce         <= 1'b0;
    end else begin
      state          <= state_n;
      frame_cnt      <= frame_cnt_n;
      hitcnt         <= hitcnt_n;
      speed          <= speed_n;
      hdir           <= hdir_n;
      vdir           <= vdir_n;
      ball_horiz_vel <= hvel_n;
      ball_vert_vel  <= vvel_n;
      serving        <= serving_n;
      bounce         <= bounce_n;
    end
  end

  // Next-state, direction/speed resolution and output codes.
  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    hitcnt_n    = hitcnt;
    speed_n     = speed;
    hdir_n      = hdir;
    vdir_n      = vdir;
    hvel_n      = ball_horiz_vel;
    vvel_n      = ball_vert_vel;
    serving_n   = serving;
    bounce_n    = 1'b0;
    clear_c     = 1'b0;

    case (state)
      SERVE: begin
        if (frame_start_c) begin
          if (serve) begin
            frame_cnt_n = '0;
          end else if (frame_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            // Launch: drop anything latched while held, start slow, heading right/down.
            state_n     = PLAY;
            frame_cnt_n = '0;
            hitcnt_n    = '0;
            speed_n     = VEL_W'(1);
            hdir_n      = DIR_RIGHT;
            vdir_n      = DIR_DOWN;
            clear_c     = 1'b1;
            serving_n   = 1'b0;
            hvel_n      = vel_encode(VEL_W'(H_CENTER), DIR_RIGHT, VEL_W'(1));
            vvel_n      = vel_encode(VEL_W'(V_CENTER), DIR_DOWN, VEL_W'(1));
          end else begin
            frame_cnt_n = frame_cnt + 1'b1;
          end
        end
      end

      PLAY: begin
        if (frame_start_c) begin
          if (serve) begin
            state_n     = SERVE;
            frame_cnt_n = '0;
            serving_n   = 1'b1;
            hvel_n      = VEL_W'(H_CENTER);
            vvel_n      = VEL_W'(V_CENTER);
          end else begin
            state_n = EVAL;
          end
        end
      end

      EVAL: begin
        state_n = APPLY;
        // Opposite walls in the same frame means the ball straddled; just reverse.
        if (hit_l && hit_r)  hdir_n = ~hdir;
        else if (hit_l)      hdir_n = DIR_RIGHT;
        else if (hit_r)      hdir_n = DIR_LEFT;

        if (hit_t && hit_b)  vdir_n = ~vdir;
        else if (hit_t)      vdir_n = DIR_DOWN;
        else if (hit_b)      vdir_n = DIR_UP;
        else if (hit_o)      vdir_n = ~vdir;

        if (hit_o) begin
          if (hitcnt == HIT_W'(HITS_PER_SPEEDUP - 1)) begin
            hitcnt_n = '0;
            if (speed < VEL_W'(MAX_SPEED)) speed_n = speed + 1'b1;
          end else begin
            hitcnt_n = hitcnt + 1'b1;
          end
        end

        hvel_n   = vel_encode(VEL_W'(H_CENTER), hdir_n, speed_n);
        vvel_n   = vel_encode(VEL_W'(V_CENTER), vdir_n, speed_n);
        bounce_n = (hdir_n != hdir) || (vdir_n != vdir);
      end

      APPLY: begin
        clear_c = 1'b1;
        state_n = PLAY;
      end

      default: state_n = SERVE;
    endcase
  end

endmodule
